// File: rtl/bfly_starve_ctrl.sv
// bfly_starve_ctrl: starvation-avoidance front end for the butterfly TCDM network.
// Tracks consecutive denied cycles per master and temporarily boosts one starved
// master: first by masking same-bank competitors (BOOST), then by masking every
// other master (EXCL). Address and data bypass this block.
// Optional build macro: BFLY_STARVE_STATS_EN adds boost/escalation event counters.
module bfly_starve_ctrl #(
   parameter int unsigned NumIn        = 32,
   parameter int unsigned NumOut       = 32,
   parameter int unsigned StarveThresh = 4,
   parameter int unsigned AddWidth     = $clog2(NumOut),
   parameter int unsigned CntWidth     = $clog2(StarveThresh + 1)
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic [NumIn-1:0]                   req_i,
   input  logic [NumIn-1:0][AddWidth-1:0]     add_i,
   output logic [NumIn-1:0]                   gnt_o,
   output logic [NumIn-1:0]                   req_o,
   input  logic [NumIn-1:0]                   gnt_i,
   output logic                               boost_o,
   output logic                               excl_o,
   output logic [$clog2(NumIn)-1:0]           boost_idx_o
`ifdef BFLY_STARVE_STATS_EN
   ,
   output logic [15:0]                        boost_cnt_o,
   output logic [15:0]                        excl_cnt_o
`endif
);

   localparam int unsigned IdxWidth = $clog2(NumIn);
   localparam logic [CntWidth-1:0] ThreshVal = CntWidth'(StarveThresh);
   localparam logic [CntWidth-1:0] DurExcl   = CntWidth'(StarveThresh - 1);
   localparam logic [CntWidth-1:0] DurMax    = {CntWidth{1'b1}};

   typedef enum logic [1:0] {
      ST_NORMAL = 2'd0,
      ST_BOOST  = 2'd1,
      ST_EXCL   = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [IdxWidth-1:0] idx_q;
   logic [IdxWidth-1:0] last_q;
   logic [IdxWidth-1:0] sel_idx;
   logic [IdxWidth-1:0] cand;
   logic [CntWidth-1:0] dur_q;
   logic [CntWidth-1:0] cnt_q [NumIn];
   logic [NumIn-1:0]    starved;
   logic                any_starved;
   logic                idx_done;
   logic                enter_boost;

   // A masked master can never be granted, whatever the network returns.
   assign gnt_o = gnt_i & req_o;

   // Completion of the boosted master's wait: granted, or request withdrawn.
   assign idx_done    = gnt_o[idx_q] | ~req_i[idx_q];
   assign enter_boost = (state_q == ST_NORMAL) && (state_d == ST_BOOST);

   // Per-master denied-cycle counters, saturating at the starvation threshold.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: counters are few and narrow, so they are reset like any other state.
         for (int i = 0; i < NumIn; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NumIn; i++) begin
            if (req_i[i] && !gnt_o[i]) begin
               if (cnt_q[i] != ThreshVal) cnt_q[i] <= cnt_q[i] + 1'b1;
            end else begin
               cnt_q[i] <= '0;
            end
         end
      end
   end

   // Starved flags and round-robin pick starting just after the last boosted master.
   always_comb begin
      // NOTE: every variable gets a default up front so no path infers a latch.
      starved     = '0;
      sel_idx     = last_q;
      cand        = last_q;
      any_starved = 1'b0;
      for (int i = 0; i < NumIn; i++) starved[i] = (cnt_q[i] == ThreshVal);
      for (int k = 1; k <= NumIn; k++) begin
         cand = last_q + IdxWidth'(k);
         if (!any_starved && starved[cand]) begin
            any_starved = 1'b1;
            sel_idx     = cand;
         end
      end
   end

   // State register plus registered boost status, index, duration and RR pointer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_NORMAL;
         idx_q       <= '0;
         dur_q       <= '0;
         last_q      <= IdxWidth'(NumIn - 1);
         boost_o     <= 1'b0;
         excl_o      <= 1'b0;
         boost_idx_o <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         boost_o <= (state_d != ST_NORMAL);
         excl_o  <= (state_d == ST_EXCL);
         if (enter_boost) begin
            idx_q       <= sel_idx;
            last_q      <= sel_idx;
            boost_idx_o <= sel_idx;
            dur_q       <= '0;
         end else if (state_q == ST_BOOST && dur_q != DurMax) begin
            dur_q <= dur_q + 1'b1;
         end
      end
   end

   // Next-state logic: a grant or withdrawal always wins over escalation.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_NORMAL: if (any_starved) state_d = ST_BOOST;
         ST_BOOST: begin
            if (idx_done)              state_d = ST_NORMAL;
            else if (dur_q == DurExcl) state_d = ST_EXCL;
         end
         ST_EXCL:   if (idx_done) state_d = ST_NORMAL;
         default:   state_d = ST_NORMAL;
      endcase
   end

   // Request gating: same-bank competitors masked in BOOST, all others in EXCL.
   always_comb begin
      req_o = req_i;
      case (state_q)
         ST_BOOST: begin
            for (int j = 0; j < NumIn; j++) begin
               if (IdxWidth'(j) != idx_q && add_i[j] == add_i[idx_q]) req_o[j] = 1'b0;
            end
         end
         ST_EXCL: begin
            req_o        = '0;
            req_o[idx_q] = req_i[idx_q];
         end
         default: req_o = req_i;
      endcase
   end

`ifdef BFLY_STARVE_STATS_EN
   // Saturating event counters for boost entries and escalations.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         boost_cnt_o <= '0;
         excl_cnt_o  <= '0;
      end else begin
         if (enter_boost && boost_cnt_o != 16'hFFFF) boost_cnt_o <= boost_cnt_o + 16'd1;
         if (state_q == ST_BOOST && state_d == ST_EXCL && excl_cnt_o != 16'hFFFF)
            excl_cnt_o <= excl_cnt_o + 16'd1;
      end
   end
`else
   // Default build: no statistics counters or ports.
`endif

endmodule
